pwm_preconditioner: RTL
=======================

Name: pwm_preconditioner

Overview:
Converts per-transducer duty/phase settings into rise/fall edge times in the time-count domain of each transducer's cycle. It sits directly downstream of the settings path and alongside time_cnt_generator. The PWM comparator consumes both this block's RISE/FALL and time_cnt_generator's TIME_CNT. The block processes transducers time-multiplexed, one per clock, through a short pipeline. It commits all outputs atomically.

Parameters:
WIDTH, 13, bit width of duty, phase, cycle, rise, fall
DEPTH, 249, number of transducers

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
DIN_VALID  in  1  single-cycle request to recompute all edges
DUTY  in  WIDTH x DEPTH  duty per transducer, in counts
PHASE  in  WIDTH x DEPTH  phase per transducer, in counts
CYCLE  in  WIDTH x DEPTH  period per transducer; must be >= 2
BUSY  out  1  high while a computation pass is in progress
RISE  out  WIDTH x DEPTH  rise time per transducer
FALL  out  WIDTH x DEPTH  fall time per transducer
DOUT_VALID  out  1  one-cycle pulse when RISE/FALL commit

Behaviour:
- Reset (RST_N low, asynchronous): all RISE/FALL = 0, DOUT_VALID = 0, BUSY = 0, state IDLE, pending = 0, shadow buffers cleared.
- Reset asserted mid-pass: the pass is aborted with no partial commit.
- States and transitions:
  - IDLE: DIN_VALID=1 -> RUN; BUSY goes high on the next cycle.
  - RUN: index counter 0..DEPTH-1 issues one transducer per cycle into the pipeline. After DEPTH-1 is issued -> DRAIN.
  - DRAIN: 2 cycles to empty the pipeline -> COMMIT.
  - COMMIT: 1 cycle. Shadow buffers are copied to RISE/FALL in that edge, and DOUT_VALID is high for exactly the following cycle. Then pending ? RUN (pending cleared) : IDLE. BUSY falls on leaving COMMIT to IDLE.
- Pipeline, per index i:
  - S0: register DUTY[i], PHASE[i], CYCLE[i].
  - S1: clamp and halve.
  - S2: wrap arithmetic, then write shadow[i].
- Latency: DIN_VALID sampled at edge E0 (IDLE) -> index 0 issued at E1 -> index DEPTH-1 written at E(DEPTH+2) -> commit at E(DEPTH+3) -> DOUT_VALID high during cycle after E(DEPTH+3).
- Input stability: DUTY/PHASE/CYCLE must be held stable while BUSY=1. The block does not snapshot them.
- DIN_VALID while BUSY: sets pending. At most one pending request is stored; further requests merge into it. A DIN_VALID in the COMMIT cycle also sets pending.
- Arithmetic (all unsigned, WIDTH+1-bit intermediates):
  - d = min(DUTY, CYCLE-1).
  - p = (PHASE >= CYCLE) ? 0 : PHASE.
  - h = d >> 1; hu = d - h.
  - RISE = p - h, plus CYCLE if negative.
  - FALL = p + hu, minus CYCLE if >= CYCLE.
- Consumer convention: output is high for t in [RISE, FALL) circularly. RISE==FALL means always off, so d=0 gives RISE=FALL=p.
- CYCLE < 2 is illegal. Behaviour is undefined but must not hang the FSM.

Decomposition:
- Shared package pwm_pkg holds:
  - WIDTH/DEPTH defaults.
  - State enum (IDLE, RUN, DRAIN, COMMIT).
  - Pipeline latency constant PIPE_LAT = 3.
- Sub-module pwm_edge_calc implements S1–S2: inputs duty/phase/cycle, outputs rise/fall, fixed latency 2. It can be unit-tested standalone.
- Top level holds the FSM, the index counter and input mux, the shadow buffers and the commit logic.

Test Plan:
- Reset mid-RUN: drive DIN_VALID, then assert RST_N low at index 100 -> RISE/FALL all 0, BUSY=0, no DOUT_VALID pulse after release.
- Basic case: CYCLE=4096, DUTY=2048, PHASE=0 on all transducers, pulse DIN_VALID -> RISE=3072, FALL=1024. DOUT_VALID pulses exactly DEPTH+4 cycles after the DIN_VALID cycle, and BUSY is high throughout.
- Clamp case: CYCLE=4096, DUTY=5000, PHASE=100 -> RISE=2149, FALL=2148. Also DUTY=1, PHASE=0 -> RISE=0, FALL=1.
- Zero duty and phase out of range: DUTY=0, PHASE=5000, CYCLE=4096 -> RISE=FALL=0. DUTY=0, PHASE=7, CYCLE=4096 -> RISE=FALL=7.
- Per-transducer isolation: transducer i gets CYCLE=2000+i, DUTY=i, PHASE=1999 -> each RISE/FALL matches the reference model, with no neighbour crosstalk in the mux or index.
- Pending handling: pulse DIN_VALID, then pulse twice more while BUSY -> exactly two DOUT_VALID pulses. The second pass starts the cycle after COMMIT and reflects inputs changed between passes.

Source files
------------

// File: rtl/pwm_preconditioner_pkg.sv
// Shared definitions for the PWM preconditioner: default sizing, the pass
// sequencer states and the issue-to-shadow pipeline depth.
package pwm_preconditioner_pkg;

  localparam int PWM_WIDTH = 13;
  localparam int PWM_DEPTH = 249;

  // Stages between issuing an index and its shadow write: S0 capture, S1, S2.
  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_preconditioner_edge_calc.sv
// Per-transducer edge arithmetic. S1 clamps duty/phase and splits the duty
// into the half before and after the phase point; S2 wraps both edges into
// [0, cycle). S2 is combinational so the caller's register completes it,
// giving two clock edges from the S0 registers to the stored result.
module pwm_preconditioner_edge_calc
  import pwm_preconditioner_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] phase_i,
  input  logic [WIDTH-1:0] cycle_i,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Saturate duty to cycle-1 so a full-on request still leaves a valid edge pair.
  function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] duty,
                                                  input logic [WIDTH-1:0] cycle);
    logic [WIDTH:0] cm1;
    cm1 = {1'b0, cycle} - (WIDTH+1)'(1);
    if ({1'b0, duty} > cm1) clamp_duty = cm1[WIDTH-1:0];
    else                    clamp_duty = duty;
  endfunction

  // Out-of-range phase falls back to zero rather than aliasing.
  function automatic logic [WIDTH-1:0] clamp_phase(input logic [WIDTH-1:0] phase,
                                                   input logic [WIDTH-1:0] cycle);
    clamp_phase = (phase >= cycle) ? '0 : phase;
  endfunction

  // p - h, folded back into the period when it goes negative.
  function automatic logic [WIDTH-1:0] wrap_sub(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] h,
                                                input logic [WIDTH-1:0] cycle);
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] adj;
    diff = {1'b0, p} - {1'b0, h};
    adj  = diff[WIDTH-1:0] + cycle;
    wrap_sub = diff[WIDTH] ? adj : diff[WIDTH-1:0];
  endfunction

  // p + hu, folded back into the period when it reaches the cycle length.
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] hu,
                                                input logic [WIDTH-1:0] cycle);
    logic [WIDTH:0] sum;
    sum = {1'b0, p} + {1'b0, hu};
    if (sum >= {1'b0, cycle}) sum = sum - {1'b0, cycle};
    wrap_add = sum[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] duty_cl;
  logic [WIDTH-1:0] phase_cl;
  logic [WIDTH-1:0] cycle_p1_q;
  logic [WIDTH-1:0] phase_p1_q;
  logic [WIDTH-1:0] h_p1_q;
  logic [WIDTH-1:0] hu_p1_q;

  assign duty_cl  = clamp_duty(duty_i, cycle_i);
  assign phase_cl = clamp_phase(phase_i, cycle_i);

  // ---- S0 -> S1: clamp and halve ----
  // Register the clamped phase and the two duty halves (odd duty puts the extra count after the phase).
  always_ff @(posedge clk_i) begin
    cycle_p1_q <= cycle_i;
    phase_p1_q <= phase_cl;
    h_p1_q     <= duty_cl >> 1;
    hu_p1_q    <= duty_cl - (duty_cl >> 1);
  end

  // ---- S1 -> S2: wrap into the period ----
  assign rise_o = wrap_sub(phase_p1_q, h_p1_q, cycle_p1_q);
  assign fall_o = wrap_add(phase_p1_q, hu_p1_q, cycle_p1_q);

endmodule

// File: rtl/pwm_preconditioner.sv
// Time-multiplexed duty/phase to rise/fall converter. One transducer is
// issued per clock into a short pipeline; results collect in shadow buffers
// and are committed to the outputs in a single edge once the pass completes.
module pwm_preconditioner
  import pwm_preconditioner_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int DEPTH = PWM_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   din_valid_i,
  input  logic [WIDTH*DEPTH-1:0] duty_i,
  input  logic [WIDTH*DEPTH-1:0] phase_i,
  input  logic [WIDTH*DEPTH-1:0] cycle_i,
  output logic                   busy_o,
  output logic [WIDTH*DEPTH-1:0] rise_o,
  output logic [WIDTH*DEPTH-1:0] fall_o,
  output logic                   dout_valid_o
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DRAIN_CYC = PIPE_LAT - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       drain_q;
  logic             pending_q;
  logic             busy_q;
  logic             dout_valid_q;

  logic [WIDTH-1:0] duty_mux;
  logic [WIDTH-1:0] phase_mux;
  logic [WIDTH-1:0] cycle_mux;

  logic             vld_p0_q;
  logic             vld_p1_q;
  logic [IDX_W-1:0] idx_p0_q;
  logic [IDX_W-1:0] idx_p1_q;
  logic [WIDTH-1:0] duty_p0_q;
  logic [WIDTH-1:0] phase_p0_q;
  logic [WIDTH-1:0] cycle_p0_q;
  logic [WIDTH-1:0] rise_s2;
  logic [WIDTH-1:0] fall_s2;

  logic [WIDTH*DEPTH-1:0] shadow_rise_q;
  logic [WIDTH*DEPTH-1:0] shadow_fall_q;
  logic [WIDTH*DEPTH-1:0] rise_q;
  logic [WIDTH*DEPTH-1:0] fall_q;

  // Pass sequencer: walks the index, drains the pipeline, commits, and replays one merged pending request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      drain_q      <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din_valid_i) begin
            state_q <= RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (din_valid_i) pending_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DRAIN: begin
          if (din_valid_i) pending_q <= 1'b1;
          drain_q <= drain_q + 1'b1;
          if (drain_q == 2'(DRAIN_CYC - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          // A request arriving in this very cycle merges with any stored one.
          dout_valid_q <= 1'b1;
          pending_q    <= 1'b0;
          if (pending_q || din_valid_i) begin
            state_q <= RUN;
            idx_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign duty_mux  = duty_i[int'(idx_q)*WIDTH +: WIDTH];
  assign phase_mux = phase_i[int'(idx_q)*WIDTH +: WIDTH];
  assign cycle_mux = cycle_i[int'(idx_q)*WIDTH +: WIDTH];

  // ---- issue -> S0: valid flags track which stages hold a live transducer ----
  // Pipeline valids are reset so an aborted pass cannot write the shadow afterwards.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p0_q <= (state_q == RUN);
      vld_p1_q <= vld_p0_q;
    end
  end

  // Data side of S0 and the index travelling with it; qualified by the valids, so left unreset.
  always_ff @(posedge clk_i) begin
    duty_p0_q  <= duty_mux;
    phase_p0_q <= phase_mux;
    cycle_p0_q <= cycle_mux;
    idx_p0_q   <= idx_q;
    idx_p1_q   <= idx_p0_q;
  end

  pwm_preconditioner_edge_calc #(
    .WIDTH(WIDTH)
  ) u_edge_calc (
    .clk_i   (clk_i),
    .duty_i  (duty_p0_q),
    .phase_i (phase_p0_q),
    .cycle_i (cycle_p0_q),
    .rise_o  (rise_s2),
    .fall_o  (fall_s2)
  );

  // ---- S2 -> shadow ----
  // Store each finished transducer's edges at its own slot in the shadow buffers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_rise_q <= '0;
      shadow_fall_q <= '0;
    end else if (vld_p1_q) begin
      shadow_rise_q[int'(idx_p1_q)*WIDTH +: WIDTH] <= rise_s2;
      shadow_fall_q[int'(idx_p1_q)*WIDTH +: WIDTH] <= fall_s2;
    end
  end

  // Atomic commit: the consumer only ever sees edges from one complete pass.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else if (state_q == COMMIT) begin
      rise_q <= shadow_rise_q;
      fall_q <= shadow_fall_q;
    end
  end

  assign busy_o       = busy_q;
  assign dout_valid_o = dout_valid_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;

endmodule
